// File: rtl/cpu_loader_pkg.sv
// Shared types, widths and the writeback-signature helper for the CPU program loader.
package cpu_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LDR_IDLE     = 3'd0,
    LDR_FILL     = 3'd1,
    LDR_PRE_RST  = 3'd2,
    LDR_BURST    = 3'd3,
    LDR_POST_RST = 3'd4,
    LDR_RUN      = 3'd5,
    LDR_DONE     = 3'd6
  } ldr_state_e;

  // Rotate the running signature left by one, then fold in the new writeback word.
  function automatic logic [WORD_W-1:0] sig_step(input logic [WORD_W-1:0] prev,
                                                 input logic [WORD_W-1:0] data);
    return {prev[WORD_W-2:0], prev[WORD_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/cpu_program_loader_buffer.sv
// Program word store: DEPTH x 32 register array, one write port and a registered read port.
module loader_buffer
  import cpu_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents survive Reset; the session word count is what invalidates them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data is zero whenever no read is requested, so it can drive the CPU directly.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/cpu_program_loader.sv
// Buffers a program from a valid/ready stream, burst-loads it into the CPU, then runs it.
// Optional writeback signature enabled by defining LOADER_SIG_EN.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH),
  parameter int RUN_CYCLES = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [WORD_W-1:0] cpu_out,
  output logic              cpu_reset,
  output logic              load_instructions,
  output logic [WORD_W-1:0] instruction,
  output logic              running,
  output logic              done,
  output logic [AW:0]       word_count
`ifdef LOADER_SIG_EN
  ,
  output logic [WORD_W-1:0] sig
`endif
);

  localparam logic [AW:0] DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [31:0] RUN_LAST    = 32'(RUN_CYCLES - 1);
  localparam bit          RUN_BOUNDED = (RUN_CYCLES != 0);

  ldr_state_e    state, state_next;
  logic [AW:0]   wc_next;
  logic [AW-1:0] rd_ptr, rd_ptr_next;
  logic [31:0]   run_cnt, run_cnt_next;
  logic          accept;

  assign accept = in_valid && in_ready && (state == LDR_FILL);

  // Next-state, buffer index and run-counter logic.
  always_comb begin
    state_next   = state;
    wc_next      = word_count;
    rd_ptr_next  = rd_ptr;
    run_cnt_next = run_cnt;
    case (state)
      LDR_IDLE, LDR_DONE: begin
        if (start) begin
          state_next = LDR_FILL;
          wc_next    = '0;
        end else begin
          state_next = state;
        end
      end
      LDR_FILL: begin
        if (accept) begin
          wc_next = word_count + (AW+1)'(1);
          if (in_last || (word_count == DEPTH_W - (AW+1)'(1))) begin
            state_next = LDR_PRE_RST;
          end else begin
            state_next = LDR_FILL;
          end
        end else begin
          state_next = LDR_FILL;
        end
      end
      LDR_PRE_RST: begin
        state_next  = LDR_BURST;
        rd_ptr_next = '0;
      end
      LDR_BURST: begin
        if ({1'b0, rd_ptr} == word_count - (AW+1)'(1)) begin
          state_next = LDR_POST_RST;
        end else begin
          rd_ptr_next = rd_ptr + AW'(1);
        end
      end
      LDR_POST_RST: begin
        state_next   = LDR_RUN;
        run_cnt_next = '0;
      end
      LDR_RUN: begin
        run_cnt_next = run_cnt + 32'd1;
        if (RUN_BOUNDED && (run_cnt == RUN_LAST)) begin
          state_next = LDR_DONE;
        end else begin
          state_next = LDR_RUN;
        end
      end
      default: state_next = LDR_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the state being entered so they change on the same edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state             <= LDR_IDLE;
      word_count        <= '0;
      rd_ptr            <= '0;
      run_cnt           <= '0;
      in_ready          <= 1'b0;
      cpu_reset         <= 1'b1;
      load_instructions <= 1'b0;
      running           <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_next;
      word_count        <= wc_next;
      rd_ptr            <= rd_ptr_next;
      run_cnt           <= run_cnt_next;
      in_ready          <= (state_next == LDR_FILL) && (wc_next < DEPTH_W);
      cpu_reset         <= !((state_next == LDR_BURST) || (state_next == LDR_RUN));
      load_instructions <= (state_next == LDR_BURST);
      running           <= (state_next == LDR_RUN);
      done              <= (state_next == LDR_DONE);
    end
  end

  loader_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .Reset (Reset),
    .we    (accept && !Reset),
    .waddr (word_count[AW-1:0]),
    .wdata (in_data),
    .re    (state_next == LDR_BURST),
    .raddr (rd_ptr_next),
    .rdata (instruction)
  );

`ifdef LOADER_SIG_EN
  // Signature restarts with each load and accumulates only while the CPU runs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sig <= '0;
    end else if ((state == LDR_FILL) && (state_next == LDR_PRE_RST)) begin
      sig <= '0;
    end else if (state == LDR_RUN) begin
      sig <= sig_step(sig, cpu_out);
    end else begin
      sig <= sig;
    end
  end
`else
  logic unused_cpu_out;
  assign unused_cpu_out = ^cpu_out;
`endif

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader (DEPTH=4, RUN_CYCLES=10); checks sig when LOADER_SIG_EN is defined.
module tb_cpu_program_loader;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);
  localparam int RUN_CYCLES = 10;

  logic clk = 1'b0;
  logic Reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = 32'h0, cpu_out = 32'h0;
  logic in_ready, cpu_reset, load_instructions, running, done;
  logic [31:0] instruction;
  logic [AW:0] word_count;
`ifdef LOADER_SIG_EN
  logic [31:0] sig;
`endif

  cpu_program_loader #(.DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cpu_out(cpu_out), .cpu_reset(cpu_reset),
    .load_instructions(load_instructions), .instruction(instruction), .running(running),
    .done(done), .word_count(word_count)
`ifdef LOADER_SIG_EN
    , .sig(sig)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  int len_q[$];
  logic [31:0] stim_w [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 cpu_out = $urandom;
    end
  end

  // Monitor: pops the scoreboard on each burst word and tracks phase lengths.
  initial begin
    bit prev_load = 0, prev_run = 0, post_prev = 0;
    int burst_len = 0, run_len = 0, el;
    logic [31:0] sig_m = 32'h0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        prev_load = 0; prev_run = 0; post_prev = 0; burst_len = 0; run_len = 0;
      end else begin
        chk("exclusive", {63'h0, cpu_reset & load_instructions}, 64'h0);
        if (load_instructions) begin
          if (!prev_load) sig_m = 32'h0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL burst_word: unexpected instruction %0h", instruction);
          end else chk("instruction", instruction, exp_q.pop_front());
          burst_len++;
        end else if (prev_load) begin
          chk("post_rst", {cpu_reset, running, instruction}, {1'b1, 1'b0, 32'h0});
          if (len_q.size() > 0) begin
            el = len_q.pop_front();
            chk("burst_len", burst_len, el);
            chk("word_count", word_count, el);
          end
          burst_len = 0;
        end
        if (running && !prev_run) chk("run_after_post", post_prev, 1);
        if (running) begin
          run_len++;
          sig_m = {sig_m[30:0], sig_m[31]} ^ cpu_out;
        end else if (prev_run) begin
          chk("run_len", run_len, RUN_CYCLES);
          chk("done_state", {done, cpu_reset, running, in_ready}, 4'b1100);
`ifdef LOADER_SIG_EN
          chk("sig", sig, sig_m);
`endif
          run_len = 0;
        end
        post_prev = prev_load && !load_instructions;
        prev_load = load_instructions;
        prev_run = running;
      end
    end
  end

  // One load session: start, stream words with the chosen gap mode, then follow it to DONE.
  task automatic session(input int n, input bit has_last, input int mode, input bit poke, input bit rst_mid);
    int exp_n, acc, cyc;
    logic [5:0] pat;
    pat = 6'b101001;
    exp_n = (n < DEPTH) ? n : DEPTH;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("fill_entry", {word_count, done, in_ready, cpu_reset}, {(AW+1)'(0), 1'b0, 1'b1, 1'b1});
    acc = 0; cyc = 0;
    while (acc < exp_n && cyc < 100) begin
      @(posedge clk); #1;
      if ((mode == 1 && cyc < 6 && !pat[cyc]) || (mode == 2 && $urandom_range(99) < 30)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = stim_w[acc];
        in_last = has_last && (acc == n - 1);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(stim_w[acc]);
        acc++;
      end
      cyc++;
    end
    if (acc < exp_n) chk("fill_timeout", acc, exp_n);
    len_q.push_back(exp_n);
    @(posedge clk); #1;
    in_valid = (n > exp_n);
    in_data = stim_w[exp_n];
    in_last = 1'b0;
    @(negedge clk);
    chk("pre_rst", {in_ready, cpu_reset, load_instructions}, 3'b010);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("burst_start", {load_instructions, cpu_reset, in_ready}, 3'b100);
    if (rst_mid) begin
      @(posedge clk); #1 Reset = 1'b1;
      exp_q.delete();
      len_q.delete();
      @(posedge clk); #1 Reset = 1'b0;
      @(negedge clk);
      chk("reset_mid_burst", {load_instructions, cpu_reset, word_count, running, done, instruction},
          {1'b0, 1'b1, (AW+1)'(0), 1'b0, 1'b0, 32'h0});
    end else begin
      if (poke) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("done_reached", done, 1);
    end
  endtask

  initial begin
    int n;
    bit hl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {cpu_reset, load_instructions, instruction, running, done, in_ready, word_count},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, (AW+1)'(0)});
    @(posedge clk); #1 Reset = 1'b0;

    stim_w[0] = 32'h20010005; stim_w[1] = 32'h20020003; stim_w[2] = 32'h00221820;
    session(3, 1'b1, 0, 1'b1, 1'b0);
    stim_w[0] = 32'h11111111; stim_w[1] = 32'h22222222; stim_w[2] = 32'h33333333;
    session(3, 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) stim_w[i] = 32'hA0000000 + i;
    session(6, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) stim_w[i] = $urandom;
    session(3, 1'b1, 2, 1'b0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 8; i++) stim_w[i] = $urandom;
      n = $urandom_range(1, DEPTH + 2);
      hl = $urandom_range(0, 1);
      if (!hl && n < DEPTH) n = DEPTH + $urandom_range(0, 2);
      session(n, hl, 2, s[0], 1'b0);
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
